// File: rtl/cga_mac_apos_gen.sv
`default_nettype none
// ============================================================================
// Module   : cga_mac_apos_gen
// Purpose  : Address sequencer feeding ICA_15_0 into the MAC capture stage.
// Revision : 1.0
// ============================================================================
module cga_mac_apos_gen #(
  parameter logic [9:0] ECC_ADDR = 10'h04D,
  parameter int         STRIDE_W = 4
) (
  input  logic                MCLK,
  input  logic                RESETN,
  input  logic                START,
  input  logic [15:0]         BASE_15_0,
  input  logic [7:0]          CNT_7_0,
  input  logic [STRIDE_W-1:0] STRIDE,
  input  logic                DEC,
  input  logic                ABORT,
  input  logic                AACK,
  input  logic                ECCRHIN,
  output logic [15:0]         ICA_15_0,
  output logic                AVAL,
  output logic                ECCR,
  output logic                BUSY,
  output logic                DONE,
  output logic                WRAP
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t              r_state, w_stateNext;
  logic [15:0]         r_ica, w_icaNext;
  logic [8:0]          r_rem, w_remNext;
  logic [STRIDE_W-1:0] r_stride, w_strideNext;
  logic                r_dec, w_decNext;
  logic                r_aval, w_avalNext;
  logic                r_busy, w_busyNext;
  logic                r_done, w_doneNext;
  logic                r_wrap, w_wrapNext;

  logic [16:0]         w_step;
  logic [16:0]         w_stepped;
  logic [STRIDE_W-1:0] w_strideIn;

  // Bit 16 of the 17-bit result is the carry (add) or borrow (subtract).
  assign w_step     = {{(17-STRIDE_W){1'b0}}, r_stride};
  assign w_stepped  = r_dec ? ({1'b0, r_ica} - w_step) : ({1'b0, r_ica} + w_step);
  assign w_strideIn = (STRIDE == '0) ? {{(STRIDE_W-1){1'b0}}, 1'b1} : STRIDE;

  always_comb begin
    w_stateNext  = r_state;
    w_icaNext    = r_ica;
    w_remNext    = r_rem;
    w_strideNext = r_stride;
    w_decNext    = r_dec;
    w_avalNext   = r_aval;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    w_wrapNext   = r_wrap;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_stateNext  = S_ISSUE;
          w_icaNext    = BASE_15_0;
          w_remNext    = {(CNT_7_0 == 8'd0), CNT_7_0};
          w_strideNext = w_strideIn;
          w_decNext    = DEC;
          w_wrapNext   = 1'b0;
          w_avalNext   = 1'b1;
          w_busyNext   = 1'b1;
        end
      end
      S_ISSUE: begin
        // Abort wins over a coincident acknowledge; that address is not consumed.
        if (ABORT) begin
          w_stateNext = S_IDLE;
          w_avalNext  = 1'b0;
          w_busyNext  = 1'b0;
        end else if (AACK) begin
          if (r_rem > 9'd1) begin
            w_icaNext  = w_stepped[15:0];
            w_remNext  = r_rem - 9'd1;
            w_wrapNext = r_wrap | w_stepped[16];
          end else begin
            w_stateNext = S_FIN;
            w_remNext   = 9'd0;
            w_avalNext  = 1'b0;
            w_busyNext  = 1'b0;
            w_doneNext  = 1'b1;
          end
        end
      end
      S_FIN: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
        w_avalNext  = 1'b0;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state  <= S_IDLE;
      r_ica    <= 16'd0;
      r_rem    <= 9'd0;
      r_stride <= '0;
      r_dec    <= 1'b0;
      r_aval   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_ica    <= w_icaNext;
      r_rem    <= w_remNext;
      r_stride <= w_strideNext;
      r_dec    <= w_decNext;
      r_aval   <= w_avalNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
      r_wrap   <= w_wrapNext;
    end
  end

  assign ICA_15_0 = r_ica;
  assign AVAL     = r_aval;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign WRAP     = r_wrap;
  assign ECCR     = r_aval & ~ECCRHIN & (r_ica[9:0] == ECC_ADDR);

endmodule
`default_nettype wire

// File: tb/tb_cga_mac_apos_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cga_mac_apos_gen
// Purpose  : Self-checking bench for cga_mac_apos_gen (table, directed, random).
// Revision : 1.0
// ============================================================================
module tb_cga_mac_apos_gen;

  localparam logic [9:0] C_ECC_ADDR = 10'h04D;

  logic        MCLK = 1'b0;
  logic        RESETN;
  logic        START;
  logic [15:0] BASE_15_0;
  logic [7:0]  CNT_7_0;
  logic [3:0]  STRIDE;
  logic        DEC;
  logic        ABORT;
  logic        AACK;
  logic        ECCRHIN;
  logic [15:0] ICA_15_0;
  logic        AVAL;
  logic        ECCR;
  logic        BUSY;
  logic        DONE;
  logic        WRAP;

  int checks = 0;
  int errors = 0;

  cga_mac_apos_gen #(.ECC_ADDR(C_ECC_ADDR), .STRIDE_W(4)) dut (
    .MCLK(MCLK), .RESETN(RESETN), .START(START), .BASE_15_0(BASE_15_0),
    .CNT_7_0(CNT_7_0), .STRIDE(STRIDE), .DEC(DEC), .ABORT(ABORT),
    .AACK(AACK), .ECCRHIN(ECCRHIN), .ICA_15_0(ICA_15_0), .AVAL(AVAL),
    .ECCR(ECCR), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  cnt;
    logic [3:0]  stride;
    logic        dec;
    logic [15:0] expLast;
    logic        expWrap;
    int          expLen;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: address k of a sequence is base +/- k*stride as a plain integer;
  // it has wrapped once that integer leaves 0..65535.
  function automatic int modelVal(input logic [15:0] base, input int s, input logic dec, input int k);
    return dec ? (int'(base) - k * s) : (int'(base) + k * s);
  endfunction

  task automatic runSeq(input logic [15:0] base, input logic [7:0] cnt, input logic [3:0] stride,
                        input logic dec, input int pct,
                        output logic [15:0] lastIca, output logic lastWrap, output int len);
    int n, s, idx, v, vLast;
    logic a;
    n   = (cnt == 8'd0) ? 256 : int'(cnt);
    s   = (stride == 4'd0) ? 1 : int'(stride);
    idx = 0;
    len = 0;
    @(negedge MCLK);
    START = 1'b1; BASE_15_0 = base; CNT_7_0 = cnt; STRIDE = stride; DEC = dec; AACK = 1'b0;
    @(negedge MCLK);
    START = 1'b0;
    for (int cyc = 0; cyc < 4000 && idx < n; cyc++) begin
      v = modelVal(base, s, dec, idx);
      chk("seq_aval", 32'(AVAL), 32'd1);
      chk("seq_busy", 32'(BUSY), 32'd1);
      chk("seq_done", 32'(DONE), 32'd0);
      chk("seq_ica",  32'(ICA_15_0), 32'(v[15:0]));
      chk("seq_wrap", 32'(WRAP), 32'(v < 0 || v > 65535));
      chk("seq_eccr", 32'(ECCR), 32'(!ECCRHIN && (v[9:0] == C_ECC_ADDR)));
      a = ($urandom_range(99) < pct);
      if (AVAL && a) len++;
      AACK = a;
      ECCRHIN = 1'($urandom_range(1));
      @(negedge MCLK);
      if (a) idx++;
    end
    chk("seq_timeout", 32'(idx >= n), 32'd1);
    vLast = modelVal(base, s, dec, n - 1);
    chk("fin_done", 32'(DONE), 32'd1);
    chk("fin_busy", 32'(BUSY), 32'd0);
    chk("fin_aval", 32'(AVAL), 32'd0);
    chk("fin_ica",  32'(ICA_15_0), 32'(vLast[15:0]));
    lastIca  = ICA_15_0;
    lastWrap = WRAP;
    AACK = 1'b0;
    @(negedge MCLK);
    chk("idle_done", 32'(DONE), 32'd0);
    chk("idle_aval", 32'(AVAL), 32'd0);
    chk("idle_eccr", 32'(ECCR), 32'd0);
  endtask

  task automatic eccTest(input logic [15:0] base, input logic hin, input logic expEccr);
    @(negedge MCLK);
    START = 1'b1; BASE_15_0 = base; CNT_7_0 = 8'd1; STRIDE = 4'd1; DEC = 1'b0;
    ECCRHIN = hin; AACK = 1'b0;
    @(negedge MCLK);
    START = 1'b0;
    chk("ecc_aval", 32'(AVAL), 32'd1);
    chk("ecc_eccr", 32'(ECCR), 32'(expEccr));
    AACK = 1'b1;
    @(negedge MCLK);
    AACK = 1'b0;
    chk("ecc_done", 32'(DONE), 32'd1);
    chk("ecc_eccr_fin", 32'(ECCR), 32'd0);
    @(negedge MCLK);
  endtask

  initial begin
    logic [15:0] lIca;
    logic        lWrap;
    int          lLen;

    vecs[0] = '{16'h1000, 8'd4,  4'd1,  1'b0, 16'h1003, 1'b0, 4};
    vecs[1] = '{16'h0002, 8'd3,  4'd2,  1'b1, 16'hFFFE, 1'b1, 3};
    vecs[2] = '{16'hFFFF, 8'd2,  4'd0,  1'b0, 16'h0000, 1'b1, 2};
    vecs[3] = '{16'h0000, 8'd0,  4'd1,  1'b0, 16'h00FF, 1'b0, 256};
    vecs[4] = '{16'h8000, 8'd16, 4'd15, 1'b1, 16'h7F1F, 1'b0, 16};
    vecs[5] = '{16'hFFF0, 8'd5,  4'd4,  1'b0, 16'h0000, 1'b1, 5};
    vecs[6] = '{16'h0010, 8'd1,  4'd7,  1'b1, 16'h0010, 1'b0, 1};

    RESETN = 1'b0; START = 1'b0; BASE_15_0 = 16'h0; CNT_7_0 = 8'h0; STRIDE = 4'h0;
    DEC = 1'b0; ABORT = 1'b0; AACK = 1'b0; ECCRHIN = 1'b1;

    @(negedge MCLK);
    chk("rst_ica",  32'(ICA_15_0), 32'd0);
    chk("rst_aval", 32'(AVAL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_wrap", 32'(WRAP), 32'd0);
    chk("rst_eccr", 32'(ECCR), 32'd0);
    RESETN = 1'b1;

    foreach (vecs[i]) begin
      runSeq(vecs[i].base, vecs[i].cnt, vecs[i].stride, vecs[i].dec, 100, lIca, lWrap, lLen);
      chk("tbl_last", 32'(lIca), 32'(vecs[i].expLast));
      chk("tbl_wrap", 32'(lWrap), 32'(vecs[i].expWrap));
      chk("tbl_len",  32'(lLen), 32'(vecs[i].expLen));
    end

    // Stall: address holds while AACK is low; START while busy is ignored.
    @(negedge MCLK);
    START = 1'b1; BASE_15_0 = 16'h0200; CNT_7_0 = 8'd2; STRIDE = 4'd1; DEC = 1'b0; AACK = 1'b0;
    @(negedge MCLK);
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_ica",  32'(ICA_15_0), 32'h0200);
      chk("stall_aval", 32'(AVAL), 32'd1);
      START = (i == 1); BASE_15_0 = 16'h1234;
      AACK  = (i == 3);
      @(negedge MCLK);
    end
    START = 1'b0;
    chk("stall_ica2", 32'(ICA_15_0), 32'h0201);
    chk("stall_nodone", 32'(DONE), 32'd0);
    @(negedge MCLK);
    AACK = 1'b0;
    chk("stall_done", 32'(DONE), 32'd1);
    @(negedge MCLK);
    chk("stall_done_once", 32'(DONE), 32'd0);
    chk("stall_idle_busy", 32'(BUSY), 32'd0);

    eccTest(16'hFC4D, 1'b0, 1'b1);
    eccTest(16'hFC4D, 1'b1, 1'b0);
    eccTest(16'h004C, 1'b0, 1'b0);

    // Abort with a coincident acknowledge on the tenth address.
    @(negedge MCLK);
    START = 1'b1; BASE_15_0 = 16'h0000; CNT_7_0 = 8'd0; STRIDE = 4'd1; DEC = 1'b0; AACK = 1'b1;
    @(negedge MCLK);
    START = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("abort_walk", 32'(ICA_15_0), 32'(i));
      @(negedge MCLK);
    end
    chk("abort_ica9", 32'(ICA_15_0), 32'h0009);
    ABORT = 1'b1;
    @(negedge MCLK);
    ABORT = 1'b0; AACK = 1'b0;
    chk("abort_aval", 32'(AVAL), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_ica",  32'(ICA_15_0), 32'h0009);
    @(negedge MCLK);
    chk("abort_done2", 32'(DONE), 32'd0);
    ABORT = 1'b1;
    @(negedge MCLK);
    ABORT = 1'b0;
    chk("abort_idle_ignored", 32'(BUSY), 32'd0);
    runSeq(16'h0000, 8'd0, 4'd1, 1'b0, 100, lIca, lWrap, lLen);
    chk("cnt0_len",  32'(lLen), 32'd256);
    chk("cnt0_last", 32'(lIca), 32'h00FF);

    // Asynchronous reset between edges in the middle of a burst.
    @(negedge MCLK);
    START = 1'b1; BASE_15_0 = 16'h5555; CNT_7_0 = 8'd10; STRIDE = 4'd1; DEC = 1'b0; AACK = 1'b1;
    @(negedge MCLK);
    START = 1'b0;
    @(negedge MCLK);
    @(negedge MCLK);
    chk("rstmid_pre", 32'(ICA_15_0), 32'h5557);
    #2 RESETN = 1'b0;
    #1;
    chk("rstmid_ica",  32'(ICA_15_0), 32'd0);
    chk("rstmid_aval", 32'(AVAL), 32'd0);
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    AACK = 1'b0;
    @(negedge MCLK);
    RESETN = 1'b1;
    @(negedge MCLK);
    chk("rstmid_idle", 32'(BUSY), 32'd0);
    chk("rstmid_hold", 32'(ICA_15_0), 32'd0);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] c;
      c = ($urandom_range(9) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      runSeq(16'($urandom), c, 4'($urandom_range(15)), 1'($urandom_range(1)),
             60, lIca, lWrap, lLen);
      chk("rnd_len", 32'(lLen), (c == 8'd0) ? 32'd256 : 32'(c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cga_mac_apos_gen.md
Name: cga_mac_apos_gen

Overview:
- Address sequencer that drives the 16-bit CPU address bus ICA_15_0 into the MAC address-capture stage. It is the initiator for the capture path.
- Loads a base address and a word count, then presents successive addresses under a valid/acknowledge handshake. Addresses step up or down by a programmable stride.
- Flags issued addresses that hit the ECC-register decode, as a pre-decode for the capture side.
- Used for block transfers, memory refresh/scrub walks and test sequencing inside the MAC gate array.

Parameters:
- ECC_ADDR, 10'h04D, low-10-bit address pattern decoded as the ECC control register.
- STRIDE_W, 4, width of the stride input; stride range is 1..2^STRIDE_W-1, and 0 is treated as 1.

Ports:
- MCLK  in  1  system clock; all state changes on the rising edge.
- RESETN  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- BASE_15_0  in  16  first address, captured on an accepted START.
- CNT_7_0  in  8  number of addresses to issue; 0 means 256.
- STRIDE  in  STRIDE_W  address increment magnitude.
- DEC  in  1  1 means subtract the stride, 0 means add it; captured with START.
- ABORT  in  1  terminate the sequence.
- AACK  in  1  consumer has taken the current address.
- ECCRHIN  in  1  active-low ECC-register enable, qualifying the decode.
- ICA_15_0  out  16  current address.
- AVAL  out  1  ICA_15_0 is valid.
- ECCR  out  1  current valid address matches ECC_ADDR and ECCRHIN=0.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle pulse when a sequence ends normally.
- WRAP  out  1  sticky flag: the address wrapped past 16'hFFFF/16'h0000 during this sequence.

Behaviour:
- Reset (async, RESETN=0):
  - State=IDLE; ICA_15_0=0; remaining count=0; stride and direction registers=0.
  - AVAL=0, ECCR=0, BUSY=0, DONE=0, WRAP=0.
  - Reset deasserting mid-sequence leaves the block in IDLE; there is no resumption.
- States: IDLE, ISSUE, FIN.
- IDLE:
  - START=1 captures BASE, CNT (0 becomes 256), STRIDE (0 becomes 1) and DEC; clears WRAP; moves to ISSUE.
  - AVAL rises on the cycle after START.
- ISSUE:
  - AVAL=1 and BUSY=1.
  - ICA_15_0 stays stable until AACK=1 is sampled.
  - AACK=1 with remaining>1: next address = ICA ± stride, modulo 2^16; remaining decrements; AVAL stays 1, giving back-to-back issue at one address per cycle.
  - A carry or borrow out of bit 15 sets WRAP.
  - AACK=1 with remaining=1: go to FIN; AVAL drops the next cycle.
- FIN: DONE=1 for exactly one cycle, BUSY=0, then IDLE. ICA_15_0 holds the last issued address.
- ABORT:
  - In ISSUE, ABORT returns to IDLE on the next edge with AVAL=0 and no DONE pulse.
  - ABORT has priority over a simultaneous AACK; that address counts as not consumed.
  - ABORT in IDLE or FIN is ignored.
- START while BUSY is ignored; START in FIN is ignored.
- ECCR is combinational: AVAL & ~ECCRHIN & (ICA_15_0[9:0]==ECC_ADDR). Address bits [15:10] are don't-care.
- All outputs except ECCR are registered.

Test Plan:
- Reset mid-ISSUE: assert RESETN=0 asynchronously between edges -> AVAL, BUSY and ICA drop to 0 immediately; the next START works normally.
- Basic burst: BASE=16'h1000, CNT=4, STRIDE=1, DEC=0, AACK held 1 -> ICA 1000, 1001, 1002, 1003 on four consecutive cycles; DONE pulses on the 5th cycle; BUSY=0 after.
- Handshake stall: BASE=16'h0200, CNT=2, AACK low for 3 cycles, then high -> ICA holds 0200 with AVAL=1 for 4 cycles, then 0201; DONE once.
- Wrap and decrement: BASE=16'h0002, CNT=3, STRIDE=2, DEC=1 -> 0002, 0000, FFFE; WRAP=1 after the third address; DONE pulses.
- ECC decode: BASE=16'hFC4D, CNT=1, ECCRHIN=0 -> ECCR=1 while AVAL. Repeat with ECCRHIN=1 -> ECCR=0. Repeat with BASE=16'h004C -> ECCR=0.
- Abort and count-0: CNT=0, BASE=0, ABORT together with AACK on the 10th address -> return to IDLE with no DONE and ICA=0009. A fresh CNT=0 run issues 256 addresses, 0000..00FF, then DONE.
